// File: rtl/dff_ctrl_pkg.sv
// Shared definitions for the dff register arbiter slice.
//   state_t  : arbiter FSM state encoding
//   pick_t   : result of a round-robin scan (found flag + winner index)
//   rr_pick  : round-robin first-set-bit search starting at a pointer
package dff_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scan vec from ptr upward, wrapping at n, and return the first set bit.
  // Only the low n bits of vec take part.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] vec,
                                    input logic [2:0]         ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned i;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      i = ({29'd0, ptr} + k) % n;
      if (k < n && !r.found && vec[i[2:0]]) begin
        r.found = 1'b1;
        r.idx   = i[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_en_async.sv
// WIDTH-bit D flip-flop with load enable and asynchronous active-high reset.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q to 0
//   en  : load enable
//   d   : data in
//   q   : registered data out
module dff_en_async #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register between N_REQ writers.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   req     : per-requester level write request, held until own gnt seen
//   wdata   : requester i data in bits [i*WIDTH +: WIDTH]
//   gnt     : registered one-hot grant, high one cycle per grant
//   q       : shared register contents
//   q_valid : one-cycle pulse, q was written on the previous edge
//   owner   : index of the requester that last wrote q (zero-extended)
//   busy    : high while a grant is outstanding
module dff_reg_arbiter
  import dff_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic [2:0]             owner,
  output logic                   busy
);

  localparam logic [2:0] LAST = 3'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       gidx_q, gidx_d;
  logic [2:0]       owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             qv_q, qv_d;
  logic [N_REQ-1:0] cand;
  pick_t            pick;
  logic [WIDTH-1:0] wsel;

  // One arbitration path serves both states: in GRANT the current grantee
  // is masked out (its req is still high), and the write bookkeeping for
  // that grantee happens on the same edge as the next pick.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    owner_d = owner_q;
    gnt_d   = '0;
    qv_d    = 1'b0;
    cand    = (state_q == ST_GRANT) ? (req & ~gnt_q) : req;
    pick    = rr_pick(MAX_REQ'(cand), ptr_q, N_REQ);

    if (state_q == ST_GRANT) begin
      owner_d = gidx_q;
      qv_d    = 1'b1;
      ptr_d   = (gidx_q == LAST) ? 3'd0 : gidx_q + 3'd1;
    end

    if (pick.found) begin
      state_d = ST_GRANT;
      gidx_d  = pick.idx;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        gnt_d[i] = (pick.idx == i[2:0]);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gidx_q == i[2:0]) wsel = wdata[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      qv_q    <= qv_d;
    end
  end

  assign busy    = (state_q == ST_GRANT);
  assign gnt     = gnt_q;
  assign q_valid = qv_q;
  assign owner   = owner_q;

  dff_en_async #(.WIDTH(WIDTH)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (busy),
    .d   (wsel),
    .q   (q)
  );

endmodule
